// File: rtl/aes_pt_word_unpacker_if.sv
// Stream bundle for aes_pt_word_unpacker: plaintext in, credit out, 32-bit word stream out.
// Slave modport is the unpacker itself; master modport is its environment.
interface aes_pt_word_unpacker_if;
    logic [0:127] pt;
    logic         pt_vld;
    logic         ct_fire;
    logic         ct_allow;
    logic [0:31]  dout;
    logic         dout_vld;
    logic         dout_rdy;
    logic         dout_last;
    logic         ovf;

    modport slave (
        input  pt, pt_vld, ct_fire, dout_rdy,
        output ct_allow, dout, dout_vld, dout_last, ovf
    );

    modport master (
        output pt, pt_vld, ct_fire, dout_rdy,
        input  ct_allow, dout, dout_vld, dout_last, ovf
    );
endinterface

// File: rtl/aes_pt_word_unpacker.sv
// Buffers un-stallable AES plaintext blocks and serialises each into four 32-bit words.
// Optional macro AES_PT_LEVEL_EN adds the level_o occupancy port.
module aes_pt_word_unpacker #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_pt_word_unpacker_if.slave bus
`ifdef AES_PT_LEVEL_EN
    ,
    output logic [AW:0]           level_o
`endif
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [0:127]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   inflight_q, inflight_d;
    logic [1:0]    widx_q, widx_d;
    logic          ovf_q, ovf_d;

    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          push;
    logic          xfer;
    logic [0:127]  head;
    logic [AW+1:0] credit_sum;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign full       = (level == DEPTH_L);
    assign empty      = (level == '0);
    assign push       = bus.pt_vld & ~full;
    assign xfer       = ~empty & bus.dout_rdy;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign credit_sum = {1'b0, inflight_q} + {1'b0, level};

    assign bus.dout      = head[{widx_q, 5'b0} +: 32];
    assign bus.dout_vld  = ~empty;
    assign bus.dout_last = ~empty & (widx_q == 2'd3);
    assign bus.ovf       = ovf_q;
    assign bus.ct_allow  = (credit_sum < DEPTH_W);

`ifdef AES_PT_LEVEL_EN
    assign level_o = level;
`endif

    // Block storage: written on an accepted push, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.pt;
        end
    end

    // Next-state for pointers, word index, overflow flag and credit counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        widx_d     = widx_q;
        ovf_d      = ovf_q;
        inflight_d = inflight_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_L;
        end
        if (bus.pt_vld && full) begin
            ovf_d = 1'b1;
        end

        if (xfer) begin
            widx_d = widx_q + 2'd1;
            if (widx_q == 2'd3) begin
                rd_ptr_d = rd_ptr_q + ONE_L;
            end
        end

        unique case ({bus.ct_fire, bus.pt_vld})
            2'b10: begin
                if (inflight_q != DEPTH_L) begin
                    inflight_d = inflight_q + ONE_L;
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - ONE_L;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            widx_q     <= '0;
            ovf_q      <= 1'b0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            widx_q     <= widx_d;
            ovf_q      <= ovf_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_aes_pt_word_unpacker.sv
// Self-checking bench for aes_pt_word_unpacker: table-driven blocks plus
// hand-written sequences, output words checked against a scoreboard queue.
module tb_aes_pt_word_unpacker;

    typedef struct {
        logic [127:0] pt;
        logic [31:0]  w0, w1, w2, w3;
    } vec_t;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   words_seen;
    bit   rnd_en;
    exp_t sbq [$];
    vec_t tbl [8];

    aes_pt_word_unpacker_if bus ();

`ifdef AES_PT_LEVEL_EN
    logic [2:0] level_o;
`endif

    aes_pt_word_unpacker #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef AES_PT_LEVEL_EN
        ,
        .level_o (level_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_words(input logic [31:0] w0, w1, w2, w3);
        sbq.push_back({w0, 1'b0});
        sbq.push_back({w1, 1'b0});
        sbq.push_back({w2, 1'b0});
        sbq.push_back({w3, 1'b1});
    endtask

    task automatic send(input logic [127:0] d, input bit fire, input bit accept);
        bus.pt      = d;
        bus.pt_vld  = 1'b1;
        bus.ct_fire = fire;
        if (accept) expect_words(d[127:96], d[95:64], d[63:32], d[31:0]);
        tick();
        bus.pt_vld  = 1'b0;
        bus.ct_fire = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.dout_vld) && n < 300) begin
            tick();
            n++;
        end
        check({name, " queue empty"}, 64'(sbq.size()), 64'd0);
        check({name, " dout_vld low"}, 64'(bus.dout_vld), 64'd0);
    endtask

    task automatic do_reset();
        sbq.delete();
        rst         = 1'b0;
        bus.pt      = '0;
        bus.pt_vld  = 1'b0;
        bus.ct_fire = 1'b0;
        bus.dout_rdy = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    // Scoreboard monitor and stall-stability checker, sampled on the falling edge.
    initial begin
        bit          stall;
        logic [31:0] hold_w;
        logic        hold_l;
        exp_t        e;
        stall = 1'b0;
        hold_w = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall dout_vld held", 64'(bus.dout_vld), 64'd1);
                    check("stall dout held", 64'(bus.dout), 64'(hold_w));
                    check("stall dout_last held", 64'(bus.dout_last), 64'(hold_l));
                end
                if (bus.dout_vld && bus.dout_rdy) begin
                    if (sbq.size() == 0) begin
                        check("unexpected word", 64'(bus.dout), 64'hDEAD_0000_0000);
                    end else begin
                        e = sbq.pop_front();
                        check("word", 64'(bus.dout), 64'(e.w));
                        check("last", 64'(bus.dout_last), 64'(e.last));
                        words_seen++;
                    end
                end
                stall  = bus.dout_vld && !bus.dout_rdy;
                hold_w = bus.dout;
                hold_l = bus.dout_last;
            end
        end
    end

    // Random consumer back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            if (rnd_en) begin
                #1;
                bus.dout_rdy = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int base;
        int n;
        n_checks   = 0;
        n_fail     = 0;
        words_seen = 0;
        rnd_en     = 1'b0;

        tbl[0] = '{128'hA0000001_A0000002_A0000003_A0000004, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
        tbl[1] = '{128'hB1111111_B2222222_B3333333_B4444444, 32'hB1111111, 32'hB2222222, 32'hB3333333, 32'hB4444444};
        tbl[2] = '{128'hC0FFEE00_C0FFEE01_C0FFEE02_C0FFEE03, 32'hC0FFEE00, 32'hC0FFEE01, 32'hC0FFEE02, 32'hC0FFEE03};
        tbl[3] = '{128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
        tbl[4] = '{128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        tbl[5] = '{128'h00000000_00000000_00000000_00000001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001};
        tbl[6] = '{128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h3C3C3C3C, 32'hC3C3C3C3};
        tbl[7] = '{128'h80000000_40000000_20000000_10000000, 32'h80000000, 32'h40000000, 32'h20000000, 32'h10000000};

        // Test 1: reset values, then one block with consumer always ready.
        do_reset();
        check("rst dout", 64'(bus.dout), 64'd0);
        check("rst dout_vld", 64'(bus.dout_vld), 64'd0);
        check("rst dout_last", 64'(bus.dout_last), 64'd0);
        check("rst ovf", 64'(bus.ovf), 64'd0);
        check("rst ct_allow", 64'(bus.ct_allow), 64'd1);
`ifdef AES_PT_LEVEL_EN
        check("rst level_o", 64'(level_o), 64'd0);
`endif
        bus.dout_rdy = 1'b1;
        send(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0, 1'b1);
        check("t1 latency vld", 64'(bus.dout_vld), 64'd1);
        check("t1 latency word0", 64'(bus.dout), 64'h00010203);
        wait_drain("t1");

        // Test 2: fill with consumer stalled, overflow on a 5th block.
        bus.dout_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send({4{32'h11000000 + 32'(i)}}, 1'b0, 1'b1);
        end
        check("t2 full ct_allow", 64'(bus.ct_allow), 64'd0);
        check("t2 full ovf", 64'(bus.ovf), 64'd0);
        check("t2 full word0", 64'(bus.dout), 64'h11000000);
`ifdef AES_PT_LEVEL_EN
        check("t2 level_o", 64'(level_o), 64'd4);
`endif
        send(128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 1'b0, 1'b0);
        check("t2 ovf set", 64'(bus.ovf), 64'd1);
        bus.dout_rdy = 1'b1;
        wait_drain("t2");
        check("t2 ovf sticky", 64'(bus.ovf), 64'd1);

        // Test 3: credits from ct_fire alone.
        bus.ct_fire = 1'b1;
        repeat (3) tick();
        check("t3 three credits allow", 64'(bus.ct_allow), 64'd1);
        tick();
        bus.ct_fire = 1'b0;
        check("t3 four credits block", 64'(bus.ct_allow), 64'd0);
        send(128'h33333333_44444444_55555555_66666666, 1'b0, 1'b1);
        check("t3 after pt still blocked", 64'(bus.ct_allow), 64'd0);
        wait_drain("t3");
        check("t3 allow restored", 64'(bus.ct_allow), 64'd1);

        // Test 4: table blocks under random back-pressure, credit-compliant source.
        do_reset();
        base = words_seen;
        rnd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!bus.ct_allow && n < 100) begin
                tick();
                n++;
            end
            check("t4 credit wait", 64'(n < 100), 64'd1);
            bus.pt      = tbl[i].pt;
            bus.pt_vld  = 1'b1;
            bus.ct_fire = 1'b1;
            expect_words(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
            tick();
            bus.pt_vld  = 1'b0;
            bus.ct_fire = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        rnd_en = 1'b0;
        tick();
        bus.dout_rdy = 1'b1;
        wait_drain("t4");
        check("t4 word count", 64'(words_seen - base), 64'd32);
        check("t4 no ovf", 64'(bus.ovf), 64'd0);

        // Test 5: full buffer, final-word pop and push in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send({4{32'h55000000 + 32'(i)}}, 1'b0, 1'b1);
        end
        check("t5 pre ovf", 64'(bus.ovf), 64'd0);
        bus.dout_rdy = 1'b1;
        repeat (3) tick();
        check("t5 at last word", 64'(bus.dout_last), 64'd1);
        send(128'h99999999_99999999_99999999_99999999, 1'b0, 1'b0);
        check("t5 ovf", 64'(bus.ovf), 64'd1);
        check("t5 next block word0", 64'(bus.dout), 64'h55000001);
        wait_drain("t5");

        // Test 6: asynchronous reset mid-block.
        bus.dout_rdy = 1'b0;
        send(128'h61616161_62626262_63636363_64646464, 1'b0, 1'b1);
        bus.dout_rdy = 1'b1;
        repeat (2) tick();
        bus.dout_rdy = 1'b0;
        check("t6 widx2 word", 64'(bus.dout), 64'h63636363);
        #2;
        sbq.delete();
        rst = 1'b0;
        #1;
        check("t6 async dout", 64'(bus.dout), 64'd0);
        check("t6 async dout_vld", 64'(bus.dout_vld), 64'd0);
        check("t6 async dout_last", 64'(bus.dout_last), 64'd0);
        check("t6 async ovf", 64'(bus.ovf), 64'd0);
        check("t6 async ct_allow", 64'(bus.ct_allow), 64'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        bus.dout_rdy = 1'b1;
        send(128'h71717171_72727272_73737373_74747474, 1'b0, 1'b1);
        check("t6 new block word0", 64'(bus.dout), 64'h71717171);
        wait_drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
